reorder_buffer: RTL

- Circular in-order reorder buffer sitting between dispatch and the register map table.
- Allocates a ROB tag per dispatched instruction; the map table records that tag as the destination's producer (its rob_entry_in).
- Captures results broadcast on the CDB and serves operand values to dispatch by tag.
- Retires completed entries in program order, driving the map table's commit/rd_commit.

---
 rtl/reorder_buffer_pkg.sv | 70 +++++++
 rtl/reorder_buffer_if.sv | 45 ++++
 rtl/reorder_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types, sizes and pointer/tag helpers for the reorder buffer.
// Tag 0 is reserved for "no producer"; entry i is addressed by tag i+1.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package reorder_buffer_pkg;

  localparam int ROB_SIZE    = 8;
  localparam int ROB_TAG_LEN = `ROB_TAG_LEN;
  localparam int PTR_W       = $clog2(ROB_SIZE);
  localparam int CNT_W       = $clog2(ROB_SIZE + 1);

  typedef logic [ROB_TAG_LEN-1:0] rob_tag_t;
  typedef logic [PTR_W-1:0]       rob_ptr_t;
  typedef logic [CNT_W-1:0]       rob_cnt_t;
  typedef logic [4:0]             reg_idx_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    reg_idx_t    rd;
    logic [31:0] value;
  } ROB_ENTRY;

  typedef struct packed {
    logic        ready;
    logic [31:0] value;
  } operand_t;

  function automatic rob_ptr_t ptr_inc(input rob_ptr_t p);
    return (p == rob_ptr_t'(ROB_SIZE - 1)) ? '0 : p + rob_ptr_t'(1);
  endfunction

  function automatic rob_tag_t ptr_to_tag(input rob_ptr_t p);
    return rob_tag_t'(p) + rob_tag_t'(1);
  endfunction

  function automatic rob_ptr_t tag_to_ptr(input rob_tag_t t);
    return rob_ptr_t'(t - rob_tag_t'(1));
  endfunction

  function automatic logic tag_in_range(input rob_tag_t t);
    return (t != '0) && (t <= rob_tag_t'(ROB_SIZE));
  endfunction

  // A completed entry wins over the CDB; the CDB only bypasses a result still in flight.
  function automatic operand_t operand_lookup(input rob_tag_t    tag,
                                              input ROB_ENTRY    entry,
                                              input logic        cdb_valid,
                                              input rob_tag_t    cdb_tag,
                                              input logic [31:0] cdb_value);
    operand_t op;
    op = '0;
    if (tag_in_range(tag)) begin
      if (entry.done) begin
        op.ready = 1'b1;
        op.value = entry.value;
      end else if (cdb_valid && (cdb_tag == tag)) begin
        op.ready = 1'b1;
        op.value = cdb_value;
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-read and commit signals of the reorder buffer.
// With `define ROB_FLUSH_EN the bundle also carries a flush request.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        dispatch_valid;
  reg_idx_t    dispatch_rd;
  logic        dispatch_ready;
  rob_tag_t    dispatch_tag;
  logic        cdb_valid;
  rob_tag_t    cdb_tag;
  logic [31:0] cdb_value;
  rob_tag_t    rs1_tag;
  rob_tag_t    rs2_tag;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        rs1_value_ready;
  logic        rs2_value_ready;
  logic        commit_valid;
  reg_idx_t    commit_rd;
  rob_tag_t    commit_tag;
  logic [31:0] commit_value;

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_value, rs1_tag, rs2_tag,
    input  dispatch_ready, dispatch_tag, rs1_value, rs2_value, rs1_value_ready,
           rs2_value_ready, commit_valid, commit_rd, commit_tag, commit_value
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_value, rs1_tag, rs2_tag,
    output dispatch_ready, dispatch_tag, rs1_value, rs2_value, rs1_value_ready,
           rs2_value_ready, commit_valid, commit_rd, commit_tag, commit_value
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags at dispatch, captures CDB results,
// serves operands by tag and retires in program order. `define ROB_FLUSH_EN adds flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clock,
  input logic             reset,
  reorder_buffer_if.slave rob
);

  ROB_ENTRY entries [ROB_SIZE];
  ROB_ENTRY head_entry;
  rob_ptr_t head;
  rob_ptr_t tail;
  rob_cnt_t count;
  rob_ptr_t cdb_idx;
  logic     alloc_fire;
  logic     commit_fire;
  logic     cdb_hit;
  logic     flush_now;
  operand_t rs1_op;
  operand_t rs2_op;

`ifdef ROB_FLUSH_EN
  assign flush_now = rob.flush;
`else
  assign flush_now = 1'b0;
`endif

  assign head_entry         = entries[head];
  assign rob.dispatch_ready = (count != rob_cnt_t'(ROB_SIZE));
  assign rob.dispatch_tag   = ptr_to_tag(tail);
  assign alloc_fire         = rob.dispatch_valid && rob.dispatch_ready;

  // The head only retires once its done flag is registered, so a CDB result lands a cycle first.
  assign commit_fire      = head_entry.valid && head_entry.done && !flush_now;
  assign rob.commit_valid = commit_fire;
  assign rob.commit_rd    = commit_fire ? head_entry.rd : `ZERO_REG;
  assign rob.commit_tag   = commit_fire ? ptr_to_tag(head) : '0;
  assign rob.commit_value = commit_fire ? head_entry.value : '0;

  assign cdb_idx = tag_to_ptr(rob.cdb_tag);
  assign cdb_hit = rob.cdb_valid && tag_in_range(rob.cdb_tag) && entries[cdb_idx].valid;

  assign rs1_op = operand_lookup(rob.rs1_tag, entries[tag_to_ptr(rob.rs1_tag)],
                                 rob.cdb_valid, rob.cdb_tag, rob.cdb_value);
  assign rs2_op = operand_lookup(rob.rs2_tag, entries[tag_to_ptr(rob.rs2_tag)],
                                 rob.cdb_valid, rob.cdb_tag, rob.cdb_value);

  assign rob.rs1_value_ready = rs1_op.ready;
  assign rob.rs1_value       = rs1_op.value;
  assign rob.rs2_value_ready = rs2_op.ready;
  assign rob.rs2_value       = rs2_op.value;

  // Allocation, capture and retirement never touch the same field of one entry:
  // the tail slot is free whenever allocation is allowed, and capture needs a valid entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_now) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) begin
        entries[tail].valid <= 1'b1;
        entries[tail].done  <= 1'b0;
        entries[tail].rd    <= rob.dispatch_rd;
        tail                <= ptr_inc(tail);
      end
      if (cdb_hit) begin
        entries[cdb_idx].done  <= 1'b1;
        entries[cdb_idx].value <= rob.cdb_value;
      end
      if (commit_fire) begin
        entries[head].valid <= 1'b0;
        head                <= ptr_inc(head);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + rob_cnt_t'(1);
        2'b01:   count <= count - rob_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
